// File: rtl/mic_volume_meter.sv
// mic_volume_meter: SPI master for a 12-bit mic ADC, peak-hold over WINDOW samples, 4-bit vol output.
// Define MIC_VOL_DECAY_EN for instant-attack / one-step-per-window decay on vol.
module mic_volume_meter #(
  parameter int CLK_DIV = 50,
  parameter int WINDOW  = 1024
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        miso,
  output logic        sclk,
  output logic        cs_n,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic [3:0]  vol,
  output logic        vol_valid
);
  localparam int CW = $clog2(2 * CLK_DIV);
  localparam int WW = $clog2(WINDOW);
  localparam logic [CW-1:0] LO_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] PH_LAST  = CW'(2 * CLK_DIV - 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);

  typedef enum logic [1:0] {GAP, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [11:0]   shift_q, shift_d;
  logic          sclk_q, sclk_d, cs_n_q, cs_n_d;
  logic [11:0]   sample_q, sample_d;
  logic          sample_valid_q, sample_valid_d, vol_valid_q, vol_valid_d;
  logic [3:0]    vol_q, vol_d;
  logic [10:0]   peak_q, peak_d;
  logic [WW-1:0] win_q, win_d;
  logic          cap, close;
  logic [10:0]   amp, pk;
  logic [3:0]    level;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    cap     = 1'b0;
    case (state_q)
      GAP: if (cnt_q == PH_LAST) begin
        state_d = SHIFT;
        cnt_d   = '0;
        bit_d   = '0;
      end
      SHIFT: begin
        if (cnt_q == LO_LAST) shift_d = {shift_q[10:0], miso};
        if (cnt_q == PH_LAST) begin
          cnt_d = '0;
          bit_d = bit_q + 1'b1;
          if (bit_q == 4'd15) begin
            state_d = DONE;
            cap     = 1'b1;
          end
        end
      end
      // DONE is the first cycle of the inter-frame gap
      default: begin
        state_d = GAP;
        cnt_d   = CW'(1);
      end
    endcase
    sclk_d = (state_d != SHIFT) || (cnt_d > LO_LAST);
    cs_n_d = state_d != SHIFT;
  end

  // Only the last 12 of the 16 shifted bits are kept; the 4 leading zeros fall off the top.
  always_comb begin
    amp            = shift_q[11] ? shift_q[10:0] :
                     ((shift_q[10:0] == '0) ? 11'h7ff : 11'h0 - shift_q[10:0]);
    pk             = (amp > peak_q) ? amp : peak_q;
    level          = pk[10:7];
    close          = cap && (win_q == WIN_LAST);
    sample_d       = cap ? shift_q : sample_q;
    sample_valid_d = cap;
    vol_valid_d    = close;
    peak_d         = cap ? (close ? '0 : pk) : peak_q;
    win_d          = cap ? (close ? '0 : win_q + 1'b1) : win_q;
`ifdef MIC_VOL_DECAY_EN
    vol_d          = close ? ((level >= vol_q) ? level : vol_q - 1'b1) : vol_q;
`else
    vol_d          = close ? level : vol_q;
`endif
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q        <= GAP;
      cnt_q          <= '0;
      bit_q          <= '0;
      shift_q        <= '0;
      sclk_q         <= 1'b1;
      cs_n_q         <= 1'b1;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      vol_q          <= '0;
      vol_valid_q    <= 1'b0;
      peak_q         <= '0;
      win_q          <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_q          <= bit_d;
      shift_q        <= shift_d;
      sclk_q         <= sclk_d;
      cs_n_q         <= cs_n_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      vol_q          <= vol_d;
      vol_valid_q    <= vol_valid_d;
      peak_q         <= peak_d;
      win_q          <= win_d;
    end
  end

  assign sclk         = sclk_q;
  assign cs_n         = cs_n_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign vol          = vol_q;
  assign vol_valid    = vol_valid_q;
endmodule

// File: tb/tb_mic_volume_meter.sv
// tb_mic_volume_meter: SPI ADC model plus window-peak reference for mic_volume_meter (CLK_DIV=2, WINDOW=4).
module tb_mic_volume_meter;
  logic        clk = 1'b0, clr_n = 1'b1, miso = 1'b0;
  logic        sclk, cs_n, sample_valid, vol_valid;
  logic [11:0] sample;
  logic [3:0]  vol;
  int          checks = 0, errors = 0, cyc = 0;
  logic [15:0] words[$];
  logic [15:0] cur_word = 16'h0800;
  int          nbit = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b1;
  logic [11:0] obs_s[4];
  logic        obs_vv[4];
  logic [3:0]  obs_v[4];
  bit          obs_to;

  mic_volume_meter #(.CLK_DIV(2), .WINDOW(4)) dut (
    .clk(clk), .clr_n(clr_n), .miso(miso), .sclk(sclk), .cs_n(cs_n),
    .sample(sample), .sample_valid(sample_valid), .vol(vol), .vol_valid(vol_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC: loads a word on cs_n fall, shifts out on sclk falling edges; idles at mid-scale
  always @(posedge clk) begin
    #1;
    if (prev_cs && !cs_n) begin
      cur_word = (words.size() > 0) ? words.pop_front() : 16'h0800;
      nbit = 0;
      miso = cur_word[15];
    end else if (!cs_n && prev_sclk && !sclk && nbit < 15) begin
      nbit++;
      miso = cur_word[15 - nbit];
    end
    prev_cs = cs_n;
    prev_sclk = sclk;
  end

  function automatic int amp_of(logic [11:0] s);
    int a = int'(s) - 2048;
    if (a < 0) a = -a;
    return (a > 2047) ? 2047 : a;
  endfunction

  function automatic logic [3:0] next_vol(logic [3:0] cur, int lvl);
`ifdef MIC_VOL_DECAY_EN
    return (lvl >= int'(cur)) ? 4'(lvl) : cur - 4'd1;
`else
    return 4'(lvl);
`endif
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1 clr_n = 1'b0;
    words.delete();
    repeat (5) @(posedge clk);
    #1 clr_n = 1'b1;
  endtask

  task automatic wait_sample(output logic [11:0] s, output logic vv, output logic [3:0] v, output bit to);
    s = '0; vv = 1'b0; v = '0; to = 1'b1;
    for (int i = 0; i < 200 && to; i++) begin
      @(posedge clk);
      #1;
      if (sample_valid) begin
        s = sample; vv = vol_valid; v = vol; to = 1'b0;
      end
    end
  endtask

  task automatic run_window(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c, input logic [11:0] d);
    logic [11:0] s; logic vv; logic [3:0] v; bit to;
    words.push_back({4'h0, a}); words.push_back({4'h0, b});
    words.push_back({4'h0, c}); words.push_back({4'h0, d});
    obs_to = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_sample(s, vv, v, to);
      obs_s[i] = s; obs_vv[i] = vv; obs_v[i] = v;
      if (to) obs_to = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit strobe = 1'b0, got = 1'b0;
    int t;
    #3 clr_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (sample_valid || vol_valid) strobe = 1'b1;
    end
    checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b want 1", cs_n); end
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk got %b want 1", sclk); end
    checks++; if (vol !== 4'd0) begin errors++; $display("FAIL reset_vol got %0d want 0", vol); end
    checks++; if (sample !== 12'h000) begin errors++; $display("FAIL reset_sample got %h want 000", sample); end
    checks++; if (strobe !== 1'b0) begin errors++; $display("FAIL reset_strobes got %b want 0", strobe); end
    clr_n = 1'b1;
    t = cyc;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      if (!cs_n) got = 1'b1;
    end
    checks++;
    if (!got || cyc - t != 4) begin errors++; $display("FAIL first_cs_fall got %0d want 4", cyc - t); end
  endtask

  task automatic test_frame();
    int t0, low = 0, rises = 0;
    bit got = 1'b0, ended = 1'b0;
    logic ps, sv = 1'b0, vv = 1'b1;
    logic [11:0] s = '0;
    do_reset();
    words.push_back(16'h0ABC);
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      if (!cs_n) got = 1'b1;
    end
    t0 = cyc; low = 1; ps = sclk;
    for (int i = 0; i < 200 && got && !ended; i++) begin
      @(posedge clk);
      #1;
      if (cs_n) begin
        ended = 1'b1; sv = sample_valid; s = sample; vv = vol_valid;
      end else begin
        low++;
        if (sclk && !ps) rises++;
      end
      ps = sclk;
    end
    checks++; if (!ended || sv !== 1'b1) begin errors++; $display("FAIL frame_valid got %b want 1", sv); end
    checks++; if (s !== 12'hABC) begin errors++; $display("FAIL frame_sample got %h want abc", s); end
    checks++; if (vv !== 1'b0) begin errors++; $display("FAIL frame_vol_valid got %b want 0", vv); end
    checks++; if (low != 64) begin errors++; $display("FAIL frame_cs_low got %0d want 64", low); end
    checks++; if (rises != 16) begin errors++; $display("FAIL frame_sclk_rises got %0d want 16", rises); end
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      #1;
      if (!cs_n) got = 1'b1;
    end
    checks++;
    if (!got || cyc - t0 != 68) begin errors++; $display("FAIL frame_period got %0d want 68", cyc - t0); end
  endtask

  task automatic test_levels();
    logic [11:0] pat[16] = '{12'h800, 12'h800, 12'h800, 12'h800,
                             12'h800, 12'h880, 12'h800, 12'h800,
                             12'h800, 12'hFFF, 12'h800, 12'h800,
                             12'h000, 12'h800, 12'h800, 12'h800};
    logic [3:0] expv[4] = '{4'd0, 4'd1, 4'd15, 4'd15};
    bit bad;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      run_window(pat[4*k], pat[4*k+1], pat[4*k+2], pat[4*k+3]);
      bad = 1'b0;
      for (int i = 0; i < 4; i++) if (obs_s[i] !== pat[4*k+i]) bad = 1'b1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL levels_samples[%0d] got %h %h %h %h want %h %h %h %h", k, obs_s[0], obs_s[1], obs_s[2], obs_s[3],
                 pat[4*k], pat[4*k+1], pat[4*k+2], pat[4*k+3]);
      end
      checks++;
      if (obs_to || {obs_vv[0], obs_vv[1], obs_vv[2], obs_vv[3]} !== 4'b0001) begin
        errors++;
        $display("FAIL levels_strobe[%0d] got to=%0d vv=%b%b%b%b want to=0 vv=0001", k, obs_to, obs_vv[0], obs_vv[1], obs_vv[2], obs_vv[3]);
      end
      checks++;
      if (obs_v[3] !== expv[k]) begin errors++; $display("FAIL levels_vol[%0d] got %0d want %0d", k, obs_v[3], expv[k]); end
    end
  endtask

  task automatic test_decay();
    logic [11:0] pk[5] = '{12'hFFF, 12'h800, 12'h800, 12'h800, 12'h880};
    logic [3:0] expv[5] = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      run_window(12'h800, pk[k], 12'h800, 12'h800);
      checks++;
      if (obs_to || {obs_vv[0], obs_vv[1], obs_vv[2], obs_vv[3]} !== 4'b0001) begin
        errors++;
        $display("FAIL decay_strobe[%0d] got to=%0d vv=%b%b%b%b want to=0 vv=0001", k, obs_to, obs_vv[0], obs_vv[1], obs_vv[2], obs_vv[3]);
      end
      checks++;
      if (obs_v[3] !== expv[k]) begin errors++; $display("FAIL decay_vol[%0d] got %0d want %0d", k, obs_v[3], expv[k]); end
    end
  endtask

  task automatic test_last_sample();
`ifdef MIC_VOL_DECAY_EN
    logic [3:0] second = 4'd7;
`else
    logic [3:0] second = 4'd0;
`endif
    do_reset();
    run_window(12'h800, 12'h800, 12'h800, 12'hC00);
    checks++;
    if (obs_to || obs_vv[3] !== 1'b1 || obs_v[3] !== 4'd8) begin
      errors++; $display("FAIL last_sample_vol got to=%0d vv=%b vol=%0d want to=0 vv=1 vol=8", obs_to, obs_vv[3], obs_v[3]);
    end
    run_window(12'h800, 12'h800, 12'h800, 12'h800);
    checks++;
    if (obs_v[1] !== 4'd8) begin errors++; $display("FAIL vol_hold got %0d want 8", obs_v[1]); end
    checks++;
    if (obs_to || obs_vv[3] !== 1'b1 || obs_v[3] !== second) begin
      errors++; $display("FAIL peak_cleared got to=%0d vv=%b vol=%0d want to=0 vv=1 vol=%0d", obs_to, obs_vv[3], obs_v[3], second);
    end
  endtask

  task automatic test_random();
    logic [11:0] ws[4];
    logic [3:0] m_vol = 4'd0;
    int pk;
    bit bad;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      pk = 0;
      for (int i = 0; i < 4; i++) begin
        ws[i] = ($urandom_range(0, 2) == 0) ? 12'($urandom_range(0, 4095)) : 12'(32'h700 + $urandom_range(0, 511));
        if (amp_of(ws[i]) > pk) pk = amp_of(ws[i]);
      end
      m_vol = next_vol(m_vol, pk / 128);
      run_window(ws[0], ws[1], ws[2], ws[3]);
      bad = 1'b0;
      for (int i = 0; i < 4; i++) if (obs_s[i] !== ws[i]) bad = 1'b1;
      checks++;
      if (bad || obs_to) begin
        errors++;
        $display("FAIL rand_samples[%0d] got %h %h %h %h want %h %h %h %h", k, obs_s[0], obs_s[1], obs_s[2], obs_s[3], ws[0], ws[1], ws[2], ws[3]);
      end
      checks++;
      if ({obs_vv[0], obs_vv[1], obs_vv[2], obs_vv[3]} !== 4'b0001 || obs_v[3] !== m_vol) begin
        errors++;
        $display("FAIL rand_vol[%0d] got vv=%b%b%b%b vol=%0d want vv=0001 vol=%0d", k, obs_vv[0], obs_vv[1], obs_vv[2], obs_vv[3], obs_v[3], m_vol);
      end
    end
  endtask

  task automatic test_mid_reset();
    int rises = 0, t;
    bit got = 1'b0, bad = 1'b0, to;
    logic ps;
    logic [11:0] s;
    logic vv;
    logic [3:0] v, vvp = '0;
    do_reset();
    repeat (3) words.push_back(16'h0FFF);
    for (int i = 0; i < 2; i++) begin
      wait_sample(s, vv, v, to);
      if (to || s !== 12'hFFF) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL mid_pre_samples got %h want fff", s); end
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      if (!cs_n) got = 1'b1;
    end
    ps = sclk;
    for (int i = 0; i < 100 && got && rises < 8; i++) begin
      @(posedge clk);
      #1;
      if (sclk && !ps) rises++;
      ps = sclk;
    end
    checks++; if (rises != 8) begin errors++; $display("FAIL mid_rises got %0d want 8", rises); end
    clr_n = 1'b0;
    #1;
    checks++;
    if ({cs_n, sclk, sample_valid, vol_valid} !== 4'b1100 || sample !== 12'h000 || vol !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got cs_n=%b sclk=%b sv=%b vv=%b sample=%h vol=%0d want 1 1 0 0 000 0",
               cs_n, sclk, sample_valid, vol_valid, sample, vol);
    end
    words.delete();
    @(posedge clk);
    #1 clr_n = 1'b1;
    t = cyc;
    wait_sample(s, vv, v, to);
    checks++;
    if (to || cyc - t != 68 || s !== 12'h800) begin
      errors++; $display("FAIL mid_first_sample got dt=%0d sample=%h want dt=68 sample=800", cyc - t, s);
    end
    vvp[3] = vv;
    for (int i = 2; i >= 0; i--) begin
      wait_sample(s, vv, v, to);
      vvp[i] = vv;
      if (to) bad = 1'b1;
    end
    checks++;
    if (bad || vvp !== 4'b0001 || v !== 4'd0) begin
      errors++; $display("FAIL mid_window_restart got vv=%b vol=%0d want vv=0001 vol=0", vvp, v);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
`ifdef MIC_VOL_DECAY_EN
    test_decay();
`else
    test_levels();
`endif
    test_last_sample();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
